i2c_slave_mem: RTL

- I2C target (slave) responder: decodes START/STOP, matches a 7-bit device address, and exposes a byte-wide memory port.
- Access model is EEPROM-style: 1- or 2-byte register pointer, sequential write, random/current/sequential read.
- Used as the on-chip counterpart to the team's I2C master, both for EEPROM emulation and for loopback verification of it.
- Open-drain pad style: outputs only pull low; no clock stretching, so there is no SCL output.

---
 rtl/i2c_slave_mem.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_mem.sv
// I2C target with an EEPROM-style pointer into a byte-wide memory port.
// SCL/SDA are synchronised and glitch-filtered; SDA is only ever pulled low, SCL is never driven.
module i2c_slave_mem #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter bit         ADDR_2BYTE = 1'b0,
  parameter int         FILTER_LEN = 3
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        scl_pad_i,
  input  logic        sda_pad_i,
  output logic        sda_pad_o,
  output logic        sda_padoen_o,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        addr_hit
);

  localparam int FCW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    IGNORE  = 3'd2,
    PTR_H   = 3'd3,
    PTR_L   = 3'd4,
    WR_DATA = 3'd5,
    RD_DATA = 3'd6
  } state_t;

  logic [1:0]     scl_sync_r, sda_sync_r;
  logic [FCW-1:0] scl_cnt_r, sda_cnt_r;
  logic           scl_f_r, sda_f_r, scl_d_r, sda_d_r;
  logic           scl_rise_s, scl_fall_s, start_s, stop_s;

  state_t         state_r, state_n;
  logic [3:0]     bit_cnt_r, bit_cnt_n;
  logic           ack_r, ack_n;
  logic           rw_r, rw_n;
  logic [6:0]     rx_r, rx_n;
  logic [6:0]     tx_r, tx_n;
  logic [7:0]     rx_byte_s;
  logic           oen_r, oen_n;
  logic           we_r, we_n;
  logic           hit_r, hit_n;
  logic           busy_r, busy_n;
  logic [15:0]    ptr_r, ptr_n;
  logic [7:0]     wdata_r, wdata_n;

  // Pointer increment: 8-bit wrap in one-byte mode, 16-bit wrap otherwise.
  function automatic logic [15:0] ptr_inc(input logic [15:0] p);
    if (ADDR_2BYTE) begin
      ptr_inc = p + 16'd1;
    end else begin
      ptr_inc = {8'h00, p[7:0] + 8'd1};
    end
  endfunction

  // Two-flop synchronisers for both pad inputs (idle bus level is high).
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl_pad_i};
      sda_sync_r <= {sda_sync_r[0], sda_pad_i};
    end
  end

  // Glitch filters: follow the synced level only after FILTER_LEN differing samples in a row.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      scl_f_r   <= 1'b1;
      sda_f_r   <= 1'b1;
      scl_cnt_r <= '0;
      sda_cnt_r <= '0;
    end else begin
      if (scl_sync_r[1] == scl_f_r) begin
        scl_cnt_r <= '0;
      end else if (scl_cnt_r == FCW'(FILTER_LEN - 1)) begin
        scl_f_r   <= scl_sync_r[1];
        scl_cnt_r <= '0;
      end else begin
        scl_cnt_r <= scl_cnt_r + FCW'(1);
      end
      if (sda_sync_r[1] == sda_f_r) begin
        sda_cnt_r <= '0;
      end else if (sda_cnt_r == FCW'(FILTER_LEN - 1)) begin
        sda_f_r   <= sda_sync_r[1];
        sda_cnt_r <= '0;
      end else begin
        sda_cnt_r <= sda_cnt_r + FCW'(1);
      end
    end
  end

  // Previous filtered levels for edge and START/STOP detection.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      scl_d_r <= 1'b1;
      sda_d_r <= 1'b1;
    end else begin
      scl_d_r <= scl_f_r;
      sda_d_r <= sda_f_r;
    end
  end

  assign scl_rise_s = scl_f_r & ~scl_d_r;
  assign scl_fall_s = ~scl_f_r & scl_d_r;
  assign start_s    = scl_f_r & scl_d_r & sda_d_r & ~sda_f_r;
  assign stop_s     = scl_f_r & scl_d_r & ~sda_d_r & sda_f_r;
  assign rx_byte_s  = {rx_r, sda_f_r};

  // State and datapath registers; outputs come straight from these.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_r   <= IDLE;
      bit_cnt_r <= 4'd0;
      ack_r     <= 1'b0;
      rw_r      <= 1'b0;
      rx_r      <= 7'd0;
      tx_r      <= 7'd0;
      oen_r     <= 1'b1;
      we_r      <= 1'b0;
      hit_r     <= 1'b0;
      busy_r    <= 1'b0;
      ptr_r     <= 16'd0;
      wdata_r   <= 8'd0;
    end else begin
      state_r   <= state_n;
      bit_cnt_r <= bit_cnt_n;
      ack_r     <= ack_n;
      rw_r      <= rw_n;
      rx_r      <= rx_n;
      tx_r      <= tx_n;
      oen_r     <= oen_n;
      we_r      <= we_n;
      hit_r     <= hit_n;
      busy_r    <= busy_n;
      ptr_r     <= ptr_n;
      wdata_r   <= wdata_n;
    end
  end

  // Next-state logic: START/STOP override everything, otherwise bit-level protocol per state.
  always_comb begin
    state_n   = state_r;
    bit_cnt_n = bit_cnt_r;
    ack_n     = ack_r;
    rw_n      = rw_r;
    rx_n      = rx_r;
    tx_n      = tx_r;
    oen_n     = oen_r;
    we_n      = 1'b0;
    hit_n     = 1'b0;
    busy_n    = busy_r;
    wdata_n   = wdata_r;
    if (we_r) begin
      ptr_n = ptr_inc(ptr_r);
    end else begin
      ptr_n = ptr_r;
    end

    if (start_s) begin
      state_n   = ADDR;
      bit_cnt_n = 4'd0;
      ack_n     = 1'b0;
      oen_n     = 1'b1;
    end else if (stop_s) begin
      state_n   = IDLE;
      bit_cnt_n = 4'd0;
      ack_n     = 1'b0;
      oen_n     = 1'b1;
      busy_n    = 1'b0;
    end else begin
      case (state_r)
        IDLE, IGNORE: begin
          oen_n = 1'b1;
        end
        ADDR, PTR_H, PTR_L, WR_DATA: begin
          if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
            rx_n      = rx_byte_s[6:0];
            bit_cnt_n = bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd7) begin
              if (state_r == ADDR) begin
                if (rx_byte_s[7:1] == DEV_ADDR) begin
                  hit_n  = 1'b1;
                  busy_n = 1'b1;
                  rw_n   = rx_byte_s[0];
                end else begin
                  state_n = IGNORE;
                end
              end else if (state_r == PTR_H) begin
                ptr_n = {rx_byte_s, ptr_r[7:0]};
              end else if (state_r == PTR_L) begin
                ptr_n = {ptr_r[15:8], rx_byte_s};
              end else begin
                we_n    = 1'b1;
                wdata_n = rx_byte_s;
              end
            end else begin
              rw_n = rw_r;
            end
          end else if (scl_fall_s && (bit_cnt_r == 4'd8) && !ack_r) begin
            oen_n = 1'b0;
            ack_n = 1'b1;
          end else if (scl_fall_s && ack_r) begin
            // End of our ACK clock: release and move on, or start the first read byte.
            oen_n     = 1'b1;
            ack_n     = 1'b0;
            bit_cnt_n = 4'd0;
            if (state_r == ADDR) begin
              if (rw_r) begin
                state_n = RD_DATA;
                tx_n    = mem_rdata[6:0];
                oen_n   = mem_rdata[7];
              end else if (ADDR_2BYTE) begin
                state_n = PTR_H;
              end else begin
                state_n = PTR_L;
              end
            end else if (state_r == PTR_H) begin
              state_n = PTR_L;
            end else begin
              state_n = WR_DATA;
            end
          end else begin
            ack_n = ack_r;
          end
        end
        RD_DATA: begin
          // bit_cnt 0..7 data bits, 8 = master ACK clock, 9 = ACKed, reload on next fall.
          if (scl_rise_s) begin
            if (bit_cnt_r < 4'd8) begin
              bit_cnt_n = bit_cnt_r + 4'd1;
            end else if (bit_cnt_r == 4'd8) begin
              if (!sda_f_r) begin
                bit_cnt_n = 4'd9;
              end else begin
                state_n = IGNORE;
                busy_n  = 1'b0;
                oen_n   = 1'b1;
              end
            end else begin
              bit_cnt_n = bit_cnt_r;
            end
          end else if (scl_fall_s) begin
            if (bit_cnt_r == 4'd9) begin
              tx_n      = mem_rdata[6:0];
              oen_n     = mem_rdata[7];
              bit_cnt_n = 4'd0;
            end else if (bit_cnt_r == 4'd8) begin
              oen_n = 1'b1;
              ptr_n = ptr_inc(ptr_r);
            end else if (bit_cnt_r != 4'd0) begin
              tx_n  = {tx_r[5:0], 1'b0};
              oen_n = tx_r[6];
            end else begin
              oen_n = oen_r;
            end
          end else begin
            tx_n = tx_r;
          end
        end
        default: begin
          state_n = IDLE;
          oen_n   = 1'b1;
        end
      endcase
    end
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oen_r;
  assign mem_addr     = ptr_r;
  assign mem_wdata    = wdata_r;
  assign mem_we       = we_r;
  assign busy         = busy_r;
  assign addr_hit     = hit_r;

endmodule
